// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, single outstanding instruction-memory request,
// one-entry valid/ready output register toward decode, and redirect/squash handling.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc_out,
   input  logic [31:0] pc_plus4,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   input  logic        id_ready,
   output logic        misalign_err
);

   typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ifpc_q, ifpc_d;
   logic [31:0] ifpc4_q, ifpc4_d;
   logic        mis_q, mis_d;

   logic slot_free;
   logic start_fetch;
   logic fetch_done;

   assign slot_free   = !valid_q || id_ready;
   assign start_fetch = (state_q == IDLE) && !redirect && slot_free;
   assign fetch_done  = (state_q == BUSY) && imem_ack && !redirect;

   // State register
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; a redirect while the request is still open turns it into a drain
   // NOTE: state_d gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_fetch) state_d = BUSY;
         BUSY:    begin
                     if (imem_ack)      state_d = IDLE;
                     else if (redirect) state_d = DRAIN;
                  end
         DRAIN:   if (imem_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      imem_req = (state_q == BUSY) || (state_q == DRAIN);
   end

   // Datapath next values; redirect outranks a same-edge fetch completion
   always_comb begin
      pc_d    = pc_q;
      addr_d  = addr_q;
      valid_d = valid_q;
      instr_d = instr_q;
      ifpc_d  = ifpc_q;
      ifpc4_d = ifpc4_q;
      mis_d   = 1'b0;

      if (start_fetch) addr_d = pc_q;

      if (redirect) begin
         pc_d    = {redirect_pc[31:2], 2'b00};
         valid_d = 1'b0;
         mis_d   = |redirect_pc[1:0];
      end else if (fetch_done) begin
         instr_d = imem_rdata;
         ifpc_d  = addr_q;
         ifpc4_d = pc_plus4;
         valid_d = 1'b1;
         pc_d    = pc_plus4;
      end else if (valid_q && id_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         addr_q  <= '0;
         valid_q <= 1'b0;
         instr_q <= '0;
         ifpc_q  <= '0;
         ifpc4_q <= '0;
         mis_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         ifpc_q  <= ifpc_d;
         ifpc4_q <= ifpc4_d;
         mis_q   <= mis_d;
      end
   end

   assign pc_out       = pc_q;
   assign imem_addr    = addr_q;
   assign if_valid     = valid_q;
   assign if_instr     = instr_q;
   assign if_pc        = ifpc_q;
   assign if_pc_plus4  = ifpc4_q;
   assign misalign_err = mis_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: models adder_32 and a fixed-latency instruction memory
// whose read data is the bitwise inverse of the request address.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        id_ready;
   logic        misalign_err;

   int errors = 0;
   int checks = 0;

   logic auto_ack;
   logic ack_force;
   int   lat;
   int   wait_cnt = 0;

   always #5 clk = ~clk;

   assign pc_plus4   = pc_out + 32'd4;
   assign imem_ack   = (auto_ack && imem_req && (wait_cnt >= lat)) || ack_force;
   assign imem_rdata = ack_force ? 32'hDEAD_BEEF : ~imem_addr;

   always @(posedge clk) begin
      if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
      else                       wait_cnt <= 0;
   end

   if_fetch_stage dut (
      .clk          (clk),
      .rst          (rst),
      .pc_out       (pc_out),
      .pc_plus4     (pc_plus4),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .if_valid     (if_valid),
      .if_instr     (if_instr),
      .if_pc        (if_pc),
      .if_pc_plus4  (if_pc_plus4),
      .id_ready     (id_ready),
      .misalign_err (misalign_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      int  n;
      bit  stale_seen;

      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      id_ready    = 1'b1;
      auto_ack    = 1'b1;
      ack_force   = 1'b0;
      lat         = 0;

      // Reset held for two edges
      tick(); tick();
      check("rst_pc",     pc_out,       32'h0040_0000);
      check("rst_valid",  if_valid,     32'd0);
      check("rst_req",    imem_req,     32'd0);
      check("rst_addr",   imem_addr,    32'd0);
      check("rst_instr",  if_instr,     32'd0);
      check("rst_mis",    misalign_err, 32'd0);
      rst = 1'b0;

      // First request, zero-latency memory
      tick();
      check("first_req",  imem_req,  32'd1);
      check("first_addr", imem_addr, 32'h0040_0000);
      tick();
      check("A_valid", if_valid,    32'd1);
      check("A_pc",    if_pc,       32'h0040_0000);
      check("A_pc4",   if_pc_plus4, 32'h0040_0004);
      check("A_instr", if_instr,    32'hFFBF_FFFF);
      check("A_req",   imem_req,    32'd0);
      tick();
      check("B_busy_valid", if_valid,  32'd0);
      check("B_addr",       imem_addr, 32'h0040_0004);
      tick();
      check("B_valid", if_valid,    32'd1);
      check("B_pc",    if_pc,       32'h0040_0004);
      check("B_pc4",   if_pc_plus4, 32'h0040_0008);
      check("B_instr", if_instr,    32'hFFBF_FFFB);
      tick();
      check("C_busy_valid", if_valid, 32'd0);
      tick();
      check("C_valid", if_valid,    32'd1);
      check("C_pc",    if_pc,       32'h0040_0008);
      check("C_pc4",   if_pc_plus4, 32'h0040_000C);
      check("C_instr", if_instr,    32'hFFBF_FFF7);

      // Backpressure: outputs held, no request
      id_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", if_valid, 32'd1);
         check("bp_instr", if_instr, 32'hFFBF_FFF7);
         check("bp_req",   imem_req, 32'd0);
      end
      lat      = 3;
      id_ready = 1'b1;
      tick();
      check("bp_rel_req",   imem_req,  32'd1);
      check("bp_rel_addr",  imem_addr, 32'h0040_000C);
      check("bp_rel_valid", if_valid,  32'd0);

      // Redirect in the first BUSY cycle of a 3-cycle-latency fetch
      redirect    = 1'b1;
      redirect_pc = 32'h0040_0100;
      tick();
      redirect = 1'b0;
      check("drain_req",  imem_req,     32'd1);
      check("drain_addr", imem_addr,    32'h0040_000C);
      check("drain_pc",   pc_out,       32'h0040_0100);
      check("drain_mis",  misalign_err, 32'd0);
      stale_seen = 1'b0;
      n = 0;
      while (!(imem_req && imem_addr == 32'h0040_0100) && n < 20) begin
         if (if_valid) stale_seen = 1'b1;
         tick();
         n++;
      end
      check("redir_addr", imem_addr, 32'h0040_0100);
      n = 0;
      while (!if_valid && n < 20) begin
         tick();
         n++;
      end
      check("no_stale",    {31'd0, stale_seen}, 32'd0);
      check("redir_valid", if_valid,    32'd1);
      check("redir_pc",    if_pc,       32'h0040_0100);
      check("redir_pc4",   if_pc_plus4, 32'h0040_0104);
      check("redir_instr", if_instr,    32'hFFBF_FEFF);

      // Redirect to the top word, fetch wraps to 0
      lat         = 0;
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      check("top_squash", if_valid, 32'd0);
      check("top_req",    imem_req, 32'd0);
      check("top_pc",     pc_out,   32'hFFFF_FFFC);
      tick();
      check("top_addr", imem_addr, 32'hFFFF_FFFC);
      tick();
      check("top_ifpc",  if_pc,       32'hFFFF_FFFC);
      check("top_ifpc4", if_pc_plus4, 32'h0000_0000);
      check("top_instr", if_instr,    32'h0000_0003);
      check("wrap_pc",   pc_out,      32'h0000_0000);
      tick();
      check("wrap_addr", imem_addr, 32'h0000_0000);

      // Misaligned redirect in BUSY with ack: data discarded, one-cycle error pulse
      redirect    = 1'b1;
      redirect_pc = 32'h0040_0102;
      tick();
      redirect = 1'b0;
      check("mis_pulse", misalign_err, 32'd1);
      check("mis_pc",    pc_out,       32'h0040_0100);
      check("mis_valid", if_valid,     32'd0);
      check("mis_req",   imem_req,     32'd0);
      lat = 3;
      tick();
      check("mis_clear", misalign_err, 32'd0);
      check("mis_req2",  imem_req,     32'd1);
      check("mis_addr",  imem_addr,    32'h0040_0100);

      // Reset mid-request, then a late ack while IDLE
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      auto_ack  = 1'b0;
      ack_force = 1'b1;
      check("mr_req",   imem_req, 32'd0);
      check("mr_pc",    pc_out,   32'h0040_0000);
      check("mr_valid", if_valid, 32'd0);
      tick();
      ack_force = 1'b0;
      check("late_valid", if_valid,  32'd0);
      check("late_req",   imem_req,  32'd1);
      check("late_addr",  imem_addr, 32'h0040_0000);
      auto_ack = 1'b1;
      lat      = 0;
      tick();
      check("refetch_valid", if_valid, 32'd1);
      check("refetch_pc",    if_pc,    32'h0040_0000);
      check("refetch_instr", if_instr, 32'hFFBF_FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
